// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencing FSM encoding, x0 register id,
// and the default MUL/DIV EX latency shared with the MUL/DIV unit.
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} md_state_e;

  localparam logic [4:0] REG_X0         = 5'd0;
  localparam int         MD_LATENCY_DEF = 4;
endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in EX whose rd feeds a source actually read in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs2,
  output logic       load_use
);
  // x0 is hardwired zero, so a load into it never creates a dependency.
  assign load_use = mem_read && (rd != REG_X0) &&
                    ((rd == rs1) || (use_rs2 && (rd == rs2)));
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, EX branch flush, MUL/DIV hold FSM.
// Optional stall/flush performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = MD_LATENCY_DEF,
  parameter int CNT_W      = 4,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_EXMemRead,
  input  logic [4:0]        ID_EXRegRd,
  input  logic              ID_EXMulDiv,
  input  logic [4:0]        IF_IDRs1,
  input  logic [4:0]        IF_IDRs2,
  input  logic              IF_IDUseRs2,
  input  logic              EX_BranchTaken,
  output logic              PC_Write,
  output logic              IF_IDWrite,
  output logic              IF_IDFlush,
  output logic              ID_EXFlush,
  output logic              EX_MEMFlush,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt
);
  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic             md_done, md_done_nxt;
  logic             load_use;
  logic             br_accept;

  load_use_detect u_lud (
    .mem_read (ID_EXMemRead),
    .rd       (ID_EXRegRd),
    .rs1      (IF_IDRs1),
    .rs2      (IF_IDRs2),
    .use_rs2  (IF_IDUseRs2),
    .load_use (load_use)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_cnt  <= md_cnt_nxt;
      md_done <= md_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    md_done_nxt = 1'b0;
    br_accept   = 1'b0;
    PC_Write    = 1'b1;
    IF_IDWrite  = 1'b1;
    IF_IDFlush  = 1'b0;
    ID_EXFlush  = 1'b0;
    EX_MEMFlush = 1'b0;
    md_busy     = 1'b0;
    case (state)
      RUN: begin
        if (EX_BranchTaken) begin
          // Squashing ID also kills any load-use consumer, so no stall here.
          IF_IDFlush = 1'b1;
          ID_EXFlush = 1'b1;
          br_accept  = 1'b1;
        end else if (ID_EXMulDiv && !md_done) begin
          state_nxt   = MD_BUSY;
          md_cnt_nxt  = CNT_W'(MD_LATENCY - 2);
          PC_Write    = 1'b0;
          IF_IDWrite  = 1'b0;
          EX_MEMFlush = 1'b1;
        end else if (load_use) begin
          PC_Write   = 1'b0;
          IF_IDWrite = 1'b0;
          ID_EXFlush = 1'b1;
        end
      end
      MD_BUSY: begin
        md_busy = 1'b1;
        // md_cnt==0 is the completion cycle: the result leaves EX on this
        // edge, so the pipe advances and only MD_LATENCY-1 bubbles reach MEM.
        if (md_cnt == '0) begin
          state_nxt   = RUN;
          md_done_nxt = 1'b1;
        end else begin
          md_cnt_nxt  = md_cnt - CNT_W'(1);
          PC_Write    = 1'b0;
          IF_IDWrite  = 1'b0;
          EX_MEMFlush = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_Write && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (br_accept && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: directed vectors push expected controls,
// a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;
  localparam int PERF_W = 16;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {PC_Write, IF_IDWrite, IF_IDFlush, ID_EXFlush, EX_MEMFlush, md_busy}
  localparam logic [5:0] E_PASS = 6'b110000;
  localparam logic [5:0] E_LU   = 6'b000100;
  localparam logic [5:0] E_BR   = 6'b111100;
  localparam logic [5:0] E_MDT  = 6'b000010;
  localparam logic [5:0] E_MDB  = 6'b000011;
  localparam logic [5:0] E_MDD  = 6'b110001;

  typedef struct {
    logic [5:0]        ctl;
    bit                chk;
    logic [PERF_W-1:0] st;
    logic [PERF_W-1:0] fl;
    string             nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ID_EXMemRead = 1'b0, ID_EXMulDiv = 1'b0, IF_IDUseRs2 = 1'b0, EX_BranchTaken = 1'b0;
  logic [4:0] ID_EXRegRd = '0, IF_IDRs1 = '0, IF_IDRs2 = '0;
  logic PC_Write, IF_IDWrite, IF_IDFlush, ID_EXFlush, EX_MEMFlush, md_busy;
  logic [PERF_W-1:0] stall_cnt, flush_cnt;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.MD_LATENCY(4), .CNT_W(4), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .ID_EXMemRead(ID_EXMemRead), .ID_EXRegRd(ID_EXRegRd), .ID_EXMulDiv(ID_EXMulDiv),
    .IF_IDRs1(IF_IDRs1), .IF_IDRs2(IF_IDRs2), .IF_IDUseRs2(IF_IDUseRs2),
    .EX_BranchTaken(EX_BranchTaken),
    .PC_Write(PC_Write), .IF_IDWrite(IF_IDWrite), .IF_IDFlush(IF_IDFlush),
    .ID_EXFlush(ID_EXFlush), .EX_MEMFlush(EX_MEMFlush), .md_busy(md_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always @(negedge clk)
    if (reset)
      assert (!(EX_BranchTaken && ID_EXMulDiv)) else $error("branch and muldiv both in EX");

  // Monitor: outputs are combinational, so one expected entry per cycle.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {PC_Write, IF_IDWrite, IF_IDFlush, ID_EXFlush, EX_MEMFlush, md_busy};
        n_vec++;
        if (act !== e.ctl) begin
          n_bad++;
          $display("FAIL %s: ctl got %b want %b", e.nm, act, e.ctl);
        end
        if (e.chk) begin
          n_vec++;
          if (stall_cnt !== e.st || flush_cnt !== e.fl) begin
            n_bad++;
            $display("FAIL %s perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                     e.nm, stall_cnt, flush_cnt, e.st, e.fl);
          end
        end
      end
    end
  end

  task automatic step(input logic rst, input logic mr, input logic [4:0] rd,
                      input logic md, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic use2, input logic br, input logic [5:0] ctl,
                      input bit chk, input int st, input int fl, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ID_EXMemRead = mr; ID_EXRegRd = rd; ID_EXMulDiv = md;
    IF_IDRs1 = rs1; IF_IDRs2 = rs2; IF_IDUseRs2 = use2; EX_BranchTaken = br;
    e.ctl = ctl; e.chk = chk; e.st = PERF_W'(st); e.fl = PERF_W'(fl); e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    //   rst mr rd md rs1 rs2 u2 br  expected
    step(0, 0, 0, 0, 0, 0, 0, 0, E_PASS, 1, 0, 0, "reset_state");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_PASS, 0, 0, 0, "idle");
    step(1, 1, 5, 0, 5, 0, 0, 0, E_LU,   0, 0, 0, "lu_rs1");
    step(1, 0, 5, 0, 5, 0, 0, 0, E_PASS, 0, 0, 0, "lu_cleared");
    step(1, 1, 0, 0, 0, 0, 0, 0, E_PASS, 0, 0, 0, "lu_rd_x0");
    step(1, 1, 5, 0, 3, 5, 0, 0, E_PASS, 0, 0, 0, "lu_rs2_unused");
    step(1, 1, 5, 0, 3, 5, 1, 0, E_LU,   0, 0, 0, "lu_rs2_used");
    step(1, 1, 5, 0, 5, 0, 0, 1, E_BR,   0, 0, 0, "branch_over_lu");
    step(1, 0, 0, 1, 0, 0, 0, 0, E_MDT,  0, 0, 0, "md_trigger");
    step(1, 0, 0, 1, 0, 0, 0, 0, E_MDB,  0, 0, 0, "md_busy1");
    step(1, 0, 0, 0, 0, 0, 0, 1, E_MDB,  0, 0, 0, "md_busy2_br_ignored");
    step(1, 0, 0, 1, 0, 0, 0, 0, E_MDD,  0, 0, 0, "md_complete");
    step(1, 0, 0, 1, 0, 0, 0, 0, E_PASS, 0, 0, 0, "md_no_retrigger");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_PASS, 1, PERF ? 5 : 0, PERF ? 1 : 0, "perf_totals");
    step(1, 0, 0, 1, 0, 0, 0, 0, E_MDT,  0, 0, 0, "md2_trigger");
    step(1, 0, 0, 1, 0, 0, 0, 0, E_MDB,  0, 0, 0, "md2_busy1");
    step(0, 0, 0, 0, 0, 0, 0, 0, E_PASS, 1, 0, 0, "async_reset_in_busy");
    step(1, 0, 0, 0, 0, 0, 0, 0, E_PASS, 1, 0, 0, "after_reset");
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
